video_scandbl: RTL and testbench

VIDEO_SCANDBL -- requirements
Module: video_scandbl

---
 rtl/video_scandbl_if.sv | 35 +++
 rtl/video_scandbl.sv | 131 +++++++++++++
 tb/tb_video_scandbl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/video_scandbl_if.sv
// Signal bundle between the video timing generator and the scan doubler:
// pixel/strobe inputs toward the doubler, registered pixel and syncs back.
interface video_scandbl_if #(
   parameter int DW  = 15,
   parameter int LAW = 9
);
   logic           c3;
   logic           f1;
   logic           vga_mode;
   logic [DW-1:0]  pix_in;
   logic           tv_blank;
   logic           vga_blank;
   logic           vga_line;
   logic [LAW:0]   vga_cnt_in;
   logic [LAW:0]   vga_cnt_out;
   logic           frame_start;
   logic           hsync_in;
   logic           vsync_in;
   logic           scanl;
   logic [DW-1:0]  rgb_out;
   logic           hsync_out;
   logic           vsync_out;

   modport master (
      output c3, f1, vga_mode, pix_in, tv_blank, vga_blank, vga_line,
             vga_cnt_in, vga_cnt_out, frame_start, hsync_in, vsync_in, scanl,
      input  rgb_out, hsync_out, vsync_out
   );

   modport slave (
      input  c3, f1, vga_mode, pix_in, tv_blank, vga_blank, vga_line,
             vga_cnt_in, vga_cnt_out, frame_start, hsync_in, vsync_in, scanl,
      output rgb_out, hsync_out, vsync_out
   );
endinterface

// File: rtl/video_scandbl.sv
// TV-to-VGA scan doubler: line buffer written at the TV pixel rate, read twice at the VGA rate.
// Define SCANDBL_SCANLINES_EN to build the scanline dimming on the second VGA line.
module video_scandbl #(
   parameter int DW  = 15,
   parameter int LAW = 9
) (
   input logic             clk,
   input logic             rst_n,
   video_scandbl_if.slave  bus
);
   localparam int unsigned DEPTH = 2 ** (LAW + 1);

   localparam logic [0:0] ST_MASK = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [DW-1:0] mem_q [DEPTH];

   logic [DW-1:0] rdata_q;
   logic          blank1_q;
   logic          hs1_q;
   logic          vs1_q;

   logic [0:0]    state_q, state_d;
   logic          mode_q, mode_d;
   logic [DW-1:0] rgb_q, rgb_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;

   logic          fs_c3;
   logic          out_en;
   logic [DW-1:0] pix_vga;

   // Line buffer is deliberately not reset; the MASK state hides stale contents.
   always_ff @(posedge clk) begin
      if (bus.c3 && !bus.tv_blank) begin
         mem_q[bus.vga_cnt_in] <= bus.pix_in;
      end
   end

   // Read issued on the address strobe itself, so a same-clk write yields old data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q  <= '0;
         blank1_q <= 1'b0;
         hs1_q    <= 1'b0;
         vs1_q    <= 1'b0;
      end else if (bus.f1) begin
         rdata_q  <= mem_q[bus.vga_cnt_out];
         blank1_q <= bus.vga_blank;
         hs1_q    <= bus.hsync_in;
         vs1_q    <= bus.vsync_in;
      end
   end

`ifdef SCANDBL_SCANLINES_EN
   logic          line1_q;
   logic          dim_en;
   logic [DW-1:0] half_w;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         line1_q <= 1'b0;
      end else if (bus.f1) begin
         line1_q <= bus.vga_line;
      end
   end

   assign dim_en = mode_q & bus.scanl & line1_q;
   assign half_w = rdata_q >> 1;

   // Top bit of each 5-bit channel is cleared so no bit leaks between channels.
   always_comb begin
      pix_vga = rdata_q;
      if (dim_en) begin
         for (int unsigned i = 0; i < DW; i++) begin
            pix_vga[i] = ((i % 5) == 4) ? 1'b0 : half_w[i];
         end
      end
   end
`else
   assign pix_vga = rdata_q;
`endif

   assign fs_c3  = bus.frame_start & bus.c3;
   assign out_en = (state_q == ST_RUN);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rgb_d   = rgb_q;
      hs_d    = hs_q;
      vs_d    = vs_q;

      if (fs_c3) begin
         state_d = ST_RUN;
         mode_d  = bus.vga_mode;
      end

      if (!mode_q) begin
         if (bus.c3) begin
            rgb_d = (bus.tv_blank || !out_en) ? '0 : bus.pix_in;
            hs_d  = bus.hsync_in;
            vs_d  = bus.vsync_in;
         end
      end else if (bus.f1) begin
         rgb_d = (blank1_q || !out_en) ? '0 : pix_vga;
         hs_d  = hs1_q;
         vs_d  = vs1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_MASK;
         mode_q  <= 1'b0;
         rgb_q   <= '0;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rgb_q   <= rgb_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
      end
   end

   assign bus.rgb_out   = rgb_q;
   assign bus.hsync_out = hs_q;
   assign bus.vsync_out = vs_q;
endmodule

// File: tb/tb_video_scandbl.sv
// Directed and randomized checks of video_scandbl against a pixel-level reference model.
module tb_video_scandbl;
   localparam int DW  = 15;
   localparam int LAW = 9;
   localparam int DEPTH = 2 ** (LAW + 1);

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   video_scandbl_if #(.DW(DW), .LAW(LAW)) bus ();

   video_scandbl #(.DW(DW), .LAW(LAW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what each output should be after every clock edge.
   logic [DW-1:0] m_mem [DEPTH];
   logic          m_mode, m_run;
   logic [DW-1:0] cap_data;
   logic          cap_blank, cap_line, cap_hs, cap_vs;
   logic [DW-1:0] exp_rgb;
   logic          exp_hs, exp_vs;

   function automatic logic [DW-1:0] half(input logic [DW-1:0] x);
      return {1'b0, x[14:11], 1'b0, x[9:6], 1'b0, x[4:1]};
   endfunction

   function automatic logic dim_on(input logic mode, input logic scanl, input logic line);
`ifdef SCANDBL_SCANLINES_EN
      return mode & scanl & line;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         exp_rgb = '0; exp_hs = 1'b0; exp_vs = 1'b0;
         m_mode = 1'b0; m_run = 1'b0;
         cap_data = '0; cap_blank = 1'b0; cap_line = 1'b0; cap_hs = 1'b0; cap_vs = 1'b0;
      end else begin
         if (!m_mode && bus.c3) begin
            exp_rgb = (bus.tv_blank || !m_run) ? '0 : bus.pix_in;
            exp_hs  = bus.hsync_in;
            exp_vs  = bus.vsync_in;
         end else if (m_mode && bus.f1) begin
            if (cap_blank || !m_run) exp_rgb = '0;
            else exp_rgb = dim_on(m_mode, bus.scanl, cap_line) ? half(cap_data) : cap_data;
            exp_hs = cap_hs;
            exp_vs = cap_vs;
         end
         if (bus.f1) begin
            cap_data  = m_mem[bus.vga_cnt_out];
            cap_blank = bus.vga_blank;
            cap_line  = bus.vga_line;
            cap_hs    = bus.hsync_in;
            cap_vs    = bus.vsync_in;
         end
         if (bus.c3 && !bus.tv_blank) m_mem[bus.vga_cnt_in] = bus.pix_in;
         if (bus.frame_start && bus.c3) begin
            m_mode = bus.vga_mode;
            m_run  = 1'b1;
         end
      end
   endtask

   task automatic step(input bit c3, input bit f1);
      bus.c3 = c3;
      bus.f1 = f1;
      @(posedge clk);
      model_edge();
      #1;
      chk("rgb_model", {17'b0, bus.rgb_out}, {17'b0, exp_rgb});
      chk("hs_model", {31'b0, bus.hsync_out}, {31'b0, exp_hs});
      chk("vs_model", {31'b0, bus.vsync_out}, {31'b0, exp_vs});
   endtask

   logic hs_v;
   logic [DW-1:0] scan_l1;

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      rst_n = 1'b0;
      bus.c3 = 1'b0; bus.f1 = 1'b0; bus.vga_mode = 1'b0; bus.pix_in = '0;
      bus.tv_blank = 1'b0; bus.vga_blank = 1'b0; bus.vga_line = 1'b0;
      bus.vga_cnt_in = '0; bus.vga_cnt_out = '0; bus.frame_start = 1'b0;
      bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.scanl = 1'b0;

      repeat (3) step(1'b1, 1'b1);
      chk("rst_rgb", {17'b0, bus.rgb_out}, 32'h0);
      chk("rst_hs", {31'b0, bus.hsync_out}, 32'h0);
      chk("rst_vs", {31'b0, bus.vsync_out}, 32'h0);

      // Fill the whole buffer; no frame_start yet, so output stays black.
      rst_n = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         bus.pix_in     = 15'($urandom);
         bus.vga_cnt_in = 10'(a);
         hs_v           = a[3];
         bus.hsync_in   = hs_v;
         step(1'b1, (a % 2) == 0);
         if ((a % 128) == 0) begin
            chk("mask_black", {17'b0, bus.rgb_out}, 32'h0);
            chk("hs_follow", {31'b0, bus.hsync_out}, {31'b0, hs_v});
         end
      end
      bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;

      bus.frame_start = 1'b1; step(1'b1, 1'b0); bus.frame_start = 1'b0;
      bus.pix_in = 15'h1234; step(1'b1, 1'b0);
      chk("tv_pass", {17'b0, bus.rgb_out}, 32'h1234);
      bus.tv_blank = 1'b1; bus.pix_in = 15'h0ABC; step(1'b1, 1'b0);
      chk("tv_blank_out", {17'b0, bus.rgb_out}, 32'h0);
      bus.tv_blank = 1'b0;

      bus.vga_mode = 1'b1; bus.pix_in = 15'h2345; step(1'b1, 1'b1);
      chk("mode_hold", {17'b0, bus.rgb_out}, 32'h2345);
      bus.pix_in = 15'h3456; step(1'b0, 1'b1);
      chk("mode_hold_f1", {17'b0, bus.rgb_out}, 32'h2345);
      bus.frame_start = 1'b1; bus.pix_in = 15'h4567; step(1'b1, 1'b0); bus.frame_start = 1'b0;
      chk("mode_edge", {17'b0, bus.rgb_out}, 32'h4567);
      bus.vga_cnt_in = 10'h3FF; bus.pix_in = 15'h5555; step(1'b1, 1'b0);
      chk("vga_ignores_c3", {17'b0, bus.rgb_out}, 32'h4567);

      bus.pix_in = 15'h7FFF; bus.vga_cnt_in = 10'h005; step(1'b1, 1'b0);
      bus.vga_cnt_out = 10'h005; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; step(1'b0, 1'b1);
      bus.vga_cnt_out = 10'h00A; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      chk("vga_read", {17'b0, bus.rgb_out}, 32'h7FFF);
      chk("vga_hs", {31'b0, bus.hsync_out}, 32'h1);
      chk("vga_vs", {31'b0, bus.vsync_out}, 32'h1);

      bus.vga_cnt_out = 10'h005; bus.vga_blank = 1'b1; step(1'b0, 1'b1);
      bus.vga_blank = 1'b0; bus.vga_cnt_out = 10'h00A; step(1'b0, 1'b1);
      chk("vga_blank_out", {17'b0, bus.rgb_out}, 32'h0);
      bus.tv_blank = 1'b1; bus.pix_in = 15'h0001; bus.vga_cnt_in = 10'h005; step(1'b1, 1'b0);
      bus.tv_blank = 1'b0; bus.vga_cnt_out = 10'h005; step(1'b0, 1'b1); step(1'b0, 1'b1);
      chk("blank_no_write", {17'b0, bus.rgb_out}, 32'h7FFF);

      bus.pix_in = 15'h2AAA; bus.vga_cnt_in = 10'h005; bus.vga_cnt_out = 10'h005; step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      chk("rw_old", {17'b0, bus.rgb_out}, 32'h7FFF);
      step(1'b0, 1'b1);
      chk("rw_new", {17'b0, bus.rgb_out}, 32'h2AAA);

      bus.pix_in = 15'h7BDE; bus.vga_cnt_in = 10'h007; step(1'b1, 1'b0);
      bus.scanl = 1'b1; bus.vga_cnt_out = 10'h007; bus.vga_line = 1'b0; step(1'b0, 1'b1);
      bus.vga_line = 1'b1; step(1'b0, 1'b1);
      chk("scan_line0", {17'b0, bus.rgb_out}, 32'h7BDE);
      step(1'b0, 1'b1);
`ifdef SCANDBL_SCANLINES_EN
      scan_l1 = 15'h3DEF;
`else
      scan_l1 = 15'h7BDE;
`endif
      chk("scan_line1", {17'b0, bus.rgb_out}, {17'b0, scan_l1});
      bus.scanl = 1'b0; bus.vga_line = 1'b0;

      rst_n = 1'b0; step(1'b0, 1'b1);
      chk("rst_mid", {17'b0, bus.rgb_out}, 32'h0);
      rst_n = 1'b1; bus.pix_in = 15'h1111; step(1'b1, 1'b0);
      chk("rst_mask", {17'b0, bus.rgb_out}, 32'h0);

      for (int n = 0; n < 4000; n++) begin
         bus.pix_in      = 15'($urandom);
         bus.tv_blank    = ($urandom_range(0, 7) == 0);
         bus.vga_blank   = ($urandom_range(0, 7) == 0);
         bus.vga_line    = 1'($urandom);
         bus.scanl       = 1'($urandom);
         bus.hsync_in    = 1'($urandom);
         bus.vsync_in    = 1'($urandom);
         bus.vga_cnt_in  = 10'($urandom);
         bus.vga_cnt_out = ($urandom_range(0, 3) == 0) ? bus.vga_cnt_in : 10'($urandom);
         bus.frame_start = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 199) == 0) bus.vga_mode = ~bus.vga_mode;
         rst_n = ($urandom_range(0, 799) != 0);
         step((n % 4) == 0 || ($urandom_range(0, 15) == 0),
              (n % 2) == 0 || ($urandom_range(0, 7) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
